// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational integer ALU among
// NUM_REQ requesters, with a one-entry registered response buffer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (ready is one-hot or zero)
//   req_pc/imm/rs1_val/rs2_val, req_alu_control, req_tag
//                            per-requester operands, opcode and opaque tag
//   alu_pc/imm/rs1_val/rs2_val, alu_control
//                            winner's operands driven to the external ALU
//   alu_rd_write_control, alu_rd_write_val
//                            ALU result, captured on accept
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_tag, rsp_wr_en, rsp_data
//                            owner, tag and captured ALU result

// Per-requester slice: flags a request that sits at or above the round-robin
// pointer, i.e. in the first half of the wrapped scan.
module alu_arbiter_lane #(
    parameter int ID_W = 1,
    parameter int LANE = 0
) (
    input  logic            valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            hi_req
);
    localparam logic [ID_W-1:0] IDX = ID_W'(LANE);

    assign hi_req = valid && (IDX >= rr_ptr);
endmodule

module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][31:0]      req_pc,
    input  logic [NUM_REQ-1:0][31:0]      req_imm,
    input  logic [NUM_REQ-1:0][31:0]      req_rs1_val,
    input  logic [NUM_REQ-1:0][31:0]      req_rs2_val,
    input  logic [NUM_REQ-1:0][4:0]       req_alu_control,
    input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag,
    output logic [31:0]                   alu_pc,
    output logic [31:0]                   alu_imm,
    output logic [31:0]                   alu_rs1_val,
    output logic [31:0]                   alu_rs2_val,
    output logic [4:0]                    alu_control,
    input  logic                          alu_rd_write_control,
    input  logic [31:0]                   alu_rd_write_val,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic                          rsp_wr_en,
    output logic [31:0]                   rsp_data
);
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] hi_req;
    logic               can_accept;
    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic               grant;
    logic [ID_W-1:0]    rr_next;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            alu_arbiter_lane #(.ID_W(ID_W), .LANE(g)) u_lane (
                .valid  (req_valid[g]),
                .rr_ptr (rr_ptr),
                .hi_req (hi_req[g])
            );
        end
    endgenerate

    // The response slot frees up either when empty or when it drains this cycle.
    assign can_accept = !rsp_valid || rsp_ready;

    // Wrapped scan: the lowest index at/above rr_ptr wins; failing that, the
    // lowest valid index overall (which is the wrap-around part of the scan).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                win_idx = ID_W'(i);
            end
        end
    end

    // No grant while reset is held so nothing is accepted in the reset cycle.
    assign grant     = win_found && can_accept && !rst;
    assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign rr_next   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

    always_comb begin
        alu_pc      = '0;
        alu_imm     = '0;
        alu_rs1_val = '0;
        alu_rs2_val = '0;
        alu_control = 5'd0;
        if (grant) begin
            alu_pc      = req_pc[win_idx];
            alu_imm     = req_imm[win_idx];
            alu_rs1_val = req_rs1_val[win_idx];
            alu_rs2_val = req_rs2_val[win_idx];
            alu_control = req_alu_control[win_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_wr_en <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_wr_en <= alu_rd_write_control;
            rsp_data  <= alu_rd_write_val;
            rsp_id    <= win_idx;
            rsp_tag   <= req_tag[win_idx];
            rr_ptr    <= rr_next;
        end else if (rsp_ready) begin
            // Drain only: data fields keep their last value.
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational integer ALU between NUM_REQ requesters, e.g. the execute pipe and the address/branch-target unit.
- Arbitration is round-robin with a valid/ready handshake on every request port.
- The chosen operands and alu_control are driven onto the ALU in the grant cycle.
- The ALU result is captured into a one-entry registered response buffer, returned with requester id and tag under valid/ready.

Parameters:
- NUM_REQ, 2, number of requesters; any value >= 2.
- TAG_W, 4, width of the opaque per-request tag echoed on the response.
- ID_W, $clog2(NUM_REQ), width of the requester index (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- req_pc  in  NUM_REQ*32  PC per requester; requester i occupies bits [32*i+31:32*i].
- req_imm  in  NUM_REQ*32  immediate per requester, same packing.
- req_rs1_val  in  NUM_REQ*32  rs1 operand per requester, same packing.
- req_rs2_val  in  NUM_REQ*32  rs2 operand per requester, same packing.
- req_alu_control  in  NUM_REQ*5  ALU opcode per requester.
- req_tag  in  NUM_REQ*TAG_W  opaque tag per requester.
- alu_pc, alu_imm, alu_rs1_val, alu_rs2_val  out  32 each  operands driven to the ALU.
- alu_control  out  5  opcode driven to the ALU.
- alu_rd_write_control  in  1  write-enable returned by the ALU.
- alu_rd_write_val  in  32  result returned by the ALU.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_tag  out  TAG_W  tag of the owning request.
- rsp_wr_en  out  1  captured alu_rd_write_control.
- rsp_data  out  32  captured alu_rd_write_val.

Behaviour:
- State:
  - One-entry response buffer, EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
  - Round-robin pointer rr_ptr of width ID_W.
- can_accept = !rsp_valid | rsp_ready. Draining and refilling in the same cycle is allowed, giving a throughput of one op per cycle.
- Grant (combinational):
  - Only when can_accept=1.
  - Pick the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - req_ready = one-hot of the winner; all zeros when there is no winner or can_accept=0.
- ALU drive:
  - With a winner: the winner's pc/imm/rs1/rs2/alu_control.
  - With no winner: all operands 0 and alu_control=5'd0. Opcode 0 is a no-write op.
- Accept of requester i = req_valid[i] & req_ready[i]. On the next edge:
  - rsp_valid<=1.
  - rsp_data<=alu_rd_write_val and rsp_wr_en<=alu_rd_write_control.
  - rsp_id<=i and rsp_tag<=tag[i].
  - rr_ptr<=(i+1) mod NUM_REQ.
- Latency: accept edge to rsp_valid is 1 cycle.
- Drain without a new accept (rsp_valid & rsp_ready): rsp_valid<=0. The data fields keep their last value.
- No accept and no drain: all response fields and rr_ptr hold.
- rr_ptr changes only on an accept.
- Requester rules:
  - A requester must hold its fields stable while valid & !ready.
  - It may drop valid before it is granted; nothing is captured in that case.
- An unsupported opcode is passed through unchanged. The ALU returns wr_en=0 and data=0, and the response is still produced with those values.
- Reset values:
  - rsp_valid=0, rsp_wr_en=0, rsp_data=0, rsp_id=0, rsp_tag=0, rr_ptr=0.
  - req_ready=0 during the reset cycle.
- Reset mid-operation: a pending response is discarded and no request is accepted in the reset cycle. After reset, requester 0 wins a tie.
- Wrap: rr_ptr=NUM_REQ-1 followed by an accept from NUM_REQ-1 gives rr_ptr=0.

Test Plan:
1. Single op: req0 valid, ADD (5'd1), rs1=5, rs2=7, tag=3, rsp_ready=1 -> req_ready=2'b01 in the same cycle. Next cycle: rsp_valid=1, rsp_data=12, rsp_wr_en=1, rsp_id=0, rsp_tag=3.
2. Fairness: both requesters valid for 6 cycles, rsp_ready=1 -> grant order 0,1,0,1,0,1 and one response per cycle with matching ids and tags.
3. Backpressure: rsp_valid=1, rsp_ready=0, both requesters valid -> req_ready=0 and the response fields are stable for 3 cycles. Raise rsp_ready -> the old response drains and a new request is accepted in the same cycle; rsp_valid stays 1 with the new data.
4. No-write op: req1 alu_control=5'd0, rs1=9 -> response rsp_wr_en=0, rsp_data=0, rsp_id=1.
5. Reset mid-flight: rsp_valid=1 and rr_ptr=1, assert rst for 1 cycle with both requesters valid -> rsp_valid=0 and no accept that cycle. First grant after reset goes to req0.
6. Single-requester wrap: only req1 valid for 4 cycles with rsp_ready=1 -> req1 is granted every cycle, rr_ptr alternates 0 after each grant, and 4 responses are returned with rsp_id=1.
